// File: rtl/prbs_pkg.sv
// Shared PRBS9 definitions used by the generator, the checker and their benches.
package prbs_pkg;

    localparam int PRBS_N_DEF = 9;
    localparam int FB_TAP_DEF = 5;

    localparam logic [8:0] PRBS_SEED = 9'h1AA;

    typedef enum logic [1:0] {
        FILL,
        SEARCH,
        LOCKED
    } prbs_state_t;

endpackage

// File: rtl/prbs_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module prbs_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/prbs_checker.sv
// PRBS9 receive checker: self-synchronises a local LFSR, then free-runs and
// counts bits and errors, dropping lock when a window sees too many errors.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int PRBSn         = PRBS_N_DEF,
    parameter int FB_TAP        = FB_TAP_DEF,
    parameter int LOCK_THRESH   = 32,
    parameter int WIN_LEN       = 64,
    parameter int UNLOCK_THRESH = 8,
    parameter int CNT_W         = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_rx_bit,
    input  logic             i_clear,
    output logic             o_locked,
    output logic             o_err,
    output logic [CNT_W-1:0] o_bit_count,
    output logic [CNT_W-1:0] o_err_count
);

    localparam int FW = $clog2(PRBSn + 1);
    localparam int MW = $clog2(LOCK_THRESH + 1);
    localparam int WW = $clog2(WIN_LEN + 1);
    localparam int EW = $clog2(UNLOCK_THRESH + 1);

    prbs_state_t      r_state, w_next_state;
    logic [PRBSn-1:0] r_loc;
    logic [FW-1:0]    r_fill, w_fill_next;
    logic [MW-1:0]    r_match, w_match_next;
    logic [WW-1:0]    r_win, w_win_next;
    logic [EW-1:0]    r_werr, w_werr_next, w_werr_sum;
    logic             r_locked, r_err;
    logic             w_exp, w_mismatch, w_new, w_err_next, w_count_inc;

    assign w_exp      = r_loc[FB_TAP-1] ^ r_loc[0];
    assign w_mismatch = (i_rx_bit != w_exp);
    assign w_werr_sum = r_werr + EW'(w_mismatch);

    always_comb begin
        w_next_state = r_state;
        w_new        = i_rx_bit;
        w_fill_next  = r_fill;
        w_match_next = r_match;
        w_win_next   = r_win;
        w_werr_next  = r_werr;
        w_err_next   = 1'b0;
        w_count_inc  = 1'b0;
        if (i_enable) begin
            case (r_state)
                FILL: begin
                    w_fill_next = r_fill + FW'(1);
                    if (r_fill == FW'(PRBSn - 1)) begin
                        w_fill_next  = '0;
                        w_match_next = '0;
                        w_next_state = SEARCH;
                    end
                end
                SEARCH: begin
                    // An all-zero register predicts zeros forever, so it never counts.
                    if (!w_mismatch && (r_loc != '0)) begin
                        if (r_match == MW'(LOCK_THRESH - 1)) begin
                            w_match_next = '0;
                            w_win_next   = '0;
                            w_werr_next  = '0;
                            w_next_state = LOCKED;
                        end else begin
                            w_match_next = r_match + MW'(1);
                        end
                    end else begin
                        w_match_next = '0;
                    end
                end
                LOCKED: begin
                    w_new       = w_exp;
                    w_count_inc = 1'b1;
                    w_err_next  = w_mismatch;
                    if (w_werr_sum == EW'(UNLOCK_THRESH)) begin
                        w_win_next   = '0;
                        w_werr_next  = '0;
                        w_fill_next  = '0;
                        w_match_next = '0;
                        w_next_state = FILL;
                    end else if (r_win == WW'(WIN_LEN - 1)) begin
                        w_win_next  = '0;
                        w_werr_next = '0;
                    end else begin
                        w_win_next  = r_win + WW'(1);
                        w_werr_next = w_werr_sum;
                    end
                end
                default: w_next_state = FILL;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= FILL;
            r_loc    <= '0;
            r_fill   <= '0;
            r_match  <= '0;
            r_win    <= '0;
            r_werr   <= '0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_fill   <= w_fill_next;
            r_match  <= w_match_next;
            r_win    <= w_win_next;
            r_werr   <= w_werr_next;
            r_locked <= (w_next_state == LOCKED);
            r_err    <= w_err_next;
            if (i_enable) begin
                r_loc <= {w_new, r_loc[PRBSn-1:1]};
            end
        end
    end

    prbs_sat_counter #(.CNT_W(CNT_W)) u_bit_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (w_count_inc),
        .i_clr   (i_clear),
        .o_count (o_bit_count)
    );

    prbs_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (w_err_next),
        .i_clr   (i_clear),
        .o_count (o_err_count)
    );

    assign o_locked = r_locked;
    assign o_err    = r_err;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, error, unlock/relock, false-lock, enable and saturation cases.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        rst, en, rx, clr;
    logic        locked, err, locked2, err2;
    logic [31:0] bc, ec;
    logic [3:0]  bc2, ec2;
    logic [8:0]  gen;
    int unsigned n_err = 0;
    int unsigned n_chk = 0;

    always #5 clk = ~clk;

    prbs_checker u_dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_enable    (en),
        .i_rx_bit    (rx),
        .i_clear     (clr),
        .o_locked    (locked),
        .o_err       (err),
        .o_bit_count (bc),
        .o_err_count (ec)
    );

    // Short window keeps error-every-bit below the unlock threshold.
    prbs_checker #(.CNT_W(4), .WIN_LEN(4)) u_dut_sat (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_enable    (en),
        .i_rx_bit    (rx),
        .i_clear     (clr),
        .o_locked    (locked2),
        .o_err       (err2),
        .o_bit_count (bc2),
        .o_err_count (ec2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next_gen(output logic b);
        b   = gen[0];
        gen = {gen[4] ^ gen[0], gen[8:1]};
    endtask

    task automatic tick(input logic e, input logic b, input logic c);
        en  = e;
        rx  = b;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic flip, output logic pulse);
        logic b;
        next_gen(b);
        tick(1'b1, b ^ flip, 1'b0);
        pulse = err;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        gen = prbs_pkg::PRBS_SEED;
    endtask

    initial begin
        logic        p, b, seen;
        int unsigned pulses, nvalid, cyc, nv2;

        rst = 1'b1; en = 1'b0; rx = 1'b0; clr = 1'b0;
        gen = prbs_pkg::PRBS_SEED;
        do_reset();
        check("rst_locked", 32'(locked), 0);
        check("rst_err",    32'(err),    0);
        check("rst_bc",     bc,          0);
        check("rst_ec",     ec,          0);

        // Lock after 9 fill + 32 matching bits
        repeat (40) send(1'b0, p);
        check("lock_bit40", 32'(locked), 0);
        send(1'b0, p);
        check("lock_bit41", 32'(locked), 1);

        pulses = 0;
        repeat (1000) begin send(1'b0, p); if (p) pulses++; end
        check("clean_bc",     bc,     1000);
        check("clean_ec",     ec,     0);
        check("clean_pulses", pulses, 0);

        // Single flipped bit: one pulse, no error multiplication
        send(1'b1, p);
        check("flip_err", 32'(err), 1);
        check("flip_ec",  ec,       1);
        check("flip_bc",  bc,       1001);
        send(1'b0, p);
        check("flip_next_err", 32'(err),    0);
        check("flip_locked",   32'(locked), 1);
        pulses = 0;
        repeat (99) begin send(1'b0, p); if (p) pulses++; end
        check("flip_after_ec",     ec,     1);
        check("flip_after_pulses", pulses, 0);

        // Eight errors inside one 64-bit window drop lock on the eighth
        repeat (7) send(1'b1, p);
        check("burst7_locked", 32'(locked), 1);
        send(1'b1, p);
        check("burst8_locked", 32'(locked), 0);
        check("burst8_ec",     ec,          9);
        check("burst8_bc",     bc,          1109);
        repeat (40) send(1'b0, p);
        check("relock_bit40", 32'(locked), 0);
        check("relock_hold_bc", bc, 1109);
        check("relock_hold_ec", ec, 9);
        send(1'b0, p);
        check("relock_bit41", 32'(locked), 1);
        repeat (10) send(1'b0, p);
        check("resume_bc", bc, 1119);
        check("resume_ec", ec, 9);

        // Stuck-at-0 line
        do_reset();
        seen = 1'b0;
        repeat (500) begin tick(1'b1, 1'b0, 1'b0); seen |= locked; end
        check("stuck0_locked", 32'(seen), 0);
        check("stuck0_bc",     bc,        0);

        // Random non-PRBS stream
        do_reset();
        seen = 1'b0;
        repeat (500) begin tick(1'b1, 1'($urandom_range(0, 1)), 1'b0); seen |= locked; end
        check("random_locked", 32'(seen), 0);

        // Enable pattern 1-0-0-1, garbage on idle cycles
        do_reset();
        nvalid = 0;
        cyc    = 0;
        while (nvalid < 41 && cyc < 400) begin
            if ((cyc % 4 == 0) || (cyc % 4 == 3)) begin
                next_gen(b);
                if (nvalid == 40) check("en_pre_lock", 32'(locked), 0);
                tick(1'b1, b, 1'b0);
                nvalid++;
            end else begin
                tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
            cyc++;
        end
        check("en_nvalid", nvalid,       41);
        check("en_locked", 32'(locked),  1);
        nv2 = 0;
        repeat (20) begin
            if ((cyc % 4 == 0) || (cyc % 4 == 3)) begin
                next_gen(b);
                tick(1'b1, b, 1'b0);
                nv2++;
            end else begin
                tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
                check("en_idle_bc", bc, nv2);
            end
            cyc++;
        end
        check("en_bc", bc, nv2);

        // 4-bit counters: saturation, clear priority, reset while locked
        do_reset();
        repeat (41) send(1'b0, p);
        check("sat_locked", 32'(locked2), 1);
        repeat (15) send(1'b1, p);
        check("sat_ec15", 32'(ec2), 15);
        repeat (5) send(1'b1, p);
        check("sat_ec_hold", 32'(ec2),     15);
        check("sat_bc_hold", 32'(bc2),     15);
        check("sat_locked2", 32'(locked2), 1);
        next_gen(b);
        tick(1'b1, ~b, 1'b1);
        check("clr_ec",  32'(ec2),  0);
        check("clr_err", 32'(err2), 1);
        send(1'b1, p);
        check("clr_next_ec", 32'(ec2), 1);
        do_reset();
        check("rst_lock_locked", 32'(locked2), 0);
        check("rst_lock_bc",     32'(bc2),     0);
        check("rst_lock_ec",     32'(ec2),     0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

PRBS9 receive-side checker paired with the team's PRBS9 generator (polynomial x^9 + x^5 + 1, LSB-first output). It self-synchronises a local LFSR to the incoming bit stream, declares lock, then free-runs and compares every valid bit. It counts received bits and bit errors for BER measurement, and drops lock when the error density is too high. It sits at the far end of the link or loopback under test.

## Interface
- PRBSn, 9, LFSR length
- FB_TAP, 5, feedback tap index (expected bit = loc[FB_TAP-1] ^ loc[0])
- LOCK_THRESH, 32, consecutive correct predictions required to lock
- WIN_LEN, 64, length in valid bits of the loss-of-lock observation window
- UNLOCK_THRESH, 8, errors within one window that force loss of lock
- CNT_W, 32, width of the bit and error counters
- i_clk  in  1  single clock, all logic on rising edge
- i_reset  in  1  reset, synchronous, active-high
- i_enable  in  1  i_rx_bit is valid this cycle
- i_rx_bit  in  1  received serial bit
- i_clear  in  1  synchronous clear of both counters, does not affect lock
- o_locked  out  1  checker locked
- o_err  out  1  one-cycle pulse per mismatched bit while locked
- o_bit_count  out  CNT_W  bits checked while locked, saturating
- o_err_count  out  CNT_W  errors while locked, saturating

## Operation
- Local register loc[PRBSn-1:0]; exp = loc[FB_TAP-1] ^ loc[0]; shift is loc <= {new, loc[PRBSn-1:1]}.
- Nothing changes in a cycle without i_enable, except i_clear and i_reset.
- States: FILL, SEARCH, LOCKED.
- FILL: new = i_rx_bit; fill counter counts PRBSn valid bits, then moves to SEARCH. Match count is 0.
- SEARCH: new = i_rx_bit. A match is i_rx_bit == exp and loc != 0. A match increments the match count; anything else zeroes it. On the LOCK_THRESH-th consecutive match, go to LOCKED.
- All-zero loc never counts as a match, so a stuck-at-0 line never locks.
- LOCKED: new = exp, so i_rx_bit is ignored for the shift. Each valid bit increments bit_count. Mismatch (i_rx_bit != exp) increments err_count and pulses o_err.
- Window: counts valid bits in LOCKED, with a window error count. When the window error count reaches UNLOCK_THRESH, go to FILL immediately, even mid-window. The bit that reaches the threshold is still counted.
- Window rollover: at WIN_LEN bits, both the window counter and the window error count restart at 0.
- Counters saturate at 2^CNT_W-1 and never wrap. Counters are held, not cleared, on loss of lock.
- i_clear has priority over increment in the same cycle. That cycle's bit still drives state and window logic, but is not counted.
- Reset: state FILL; loc, fill, match and window counters are 0; all outputs 0. Reset mid-lock behaves identically.

## Timing
- All outputs are registered.
- o_err is high in the cycle after the rising edge that samples the errored bit.
- o_locked rises one cycle after the edge sampling the LOCK_THRESH-th match. With continuous i_enable, that is after bit PRBSn+LOCK_THRESH (41 with defaults).
- o_locked falls one cycle after the edge sampling the UNLOCK_THRESH-th window error.
- Counter outputs update in the same cycle as o_err.
- The first counted bit is the first valid bit after o_locked is high.
- No backpressure; a valid bit is accepted every cycle in which i_enable is high.

## Structure
- Shared package prbs_pkg: PRBSn and FB_TAP defaults (shared with the generator), the state enum (FILL, SEARCH, LOCKED), and the reset seed constant 9'h1AA used by benches.
- One sub-module, prbs_sat_counter (CNT_W, inc, clr, saturating), instantiated twice for the bit and error counters.
- State machine, loc register and window logic stay in prbs_checker.

## Test plan
- Generator with seed 9'h1AA, continuous enable, into checker -> o_locked rises after bit 41; after 1000 further bits, bit_count = 1000 and err_count = 0.
- Locked stream with one bit flipped -> a single o_err pulse, err_count = 1, lock held, and the next bits are error-free (no error multiplication).
- 8 flipped bits within 64 bits -> o_locked falls after the 8th; relock after 41 clean bits; counters hold their pre-relock values and then resume.
- i_rx_bit stuck at 0 for 500 bits, and separately a random non-PRBS stream -> o_locked never asserts.
- Enable pattern 1-0-0-1 repeated -> lock at valid bit 41; counts advance only on enabled cycles.
- CNT_W = 4 with an error every bit while keeping the window below threshold -> err_count saturates at 15. i_clear together with an error returns 0, and the next error gives 1. i_reset while locked gives o_locked = 0 and counters 0 in the next cycle.
